// File: rtl/dec_8to256.sv
// dec_8to256: registered 8-to-256 binary-to-one-hot decoder.
// The 256 one-hot lines are built from two 4-to-16 predecoders (low and high
// nibble of the code), then ANDed into a 16x16 grid and registered. Outputs
// come straight from the flops, so the module has no combinational path
// from in0 to out0/out1.
module dec_8to256 #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 256,
    parameter int HALF_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in0,
    output logic [HALF_W-1:0] out0,
    output logic [HALF_W-1:0] out1
);

    localparam int NIB_W   = 4;
    localparam int NIB_CNT = 16;

    logic [NIB_CNT-1:0] lo_hot;
    logic [NIB_CNT-1:0] hi_hot;
    logic [OUT_W-1:0]   dec_d;
    logic [OUT_W-1:0]   dec_q;

    // Predecode each nibble of the code into a 16-line one-hot group.
    always_comb begin
        lo_hot = '0;
        hi_hot = '0;
        lo_hot[in0[NIB_W-1:0]]      = 1'b1;
        hi_hot[in0[IN_W-1:NIB_W]]   = 1'b1;
    end

    // Line 16*h + l is high only when the high group selects h and the low group selects l.
    always_comb begin
        dec_d = '0;
        for (int h = 0; h < NIB_CNT; h++) begin
            dec_d[h*NIB_CNT +: NIB_CNT] = hi_hot[h] ? lo_hot : '0;
        end
    end

    // Register the decoded lines; reset forces every line low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign out0 = dec_q[HALF_W-1:0];
    assign out1 = dec_q[OUT_W-1:HALF_W];

endmodule

// File: tb/tb_dec_8to256.sv
// Scoreboard bench for dec_8to256: stimulus pushes the expected 256-bit
// one-hot word when it drives a code; a monitor pops and compares one cycle later.
module tb_dec_8to256;

    logic         clk;
    logic         rst;
    logic [7:0]   in0;
    logic [127:0] out0;
    logic [127:0] out1;

    logic [255:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    dec_8to256 dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0),
        .out0 (out0),
        .out1 (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] one_hot(input logic [7:0] code);
        logic [255:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] code, input logic [255:0] exp);
        @(negedge clk);
        in0 = code;
        exp_q.push_back(exp);
    endtask

    // Monitor: after each rising edge, compare DUT output with the oldest expectation.
    initial begin
        logic [255:0] e;
        logic [255:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {out1, out0};
                check("decode", a, e);
                check_int("popcount", $countones(a), 1);
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        in0 = 8'h05;

        // Reset holds outputs low while the clock runs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("reset_hold", {out1, out0}, 256'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(256'h20);

        // Boundaries and half split, hand-computed.
        drive(8'd0,   256'h1);
        drive(8'd127, {128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0000});
        drive(8'd128, {128'h1, 128'h0});
        drive(8'd255, {128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h0});
        drive(8'd255, {128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h0});
        drive(8'h10,  256'h1_0000);
        drive(8'h81,  {128'h2, 128'h0});

        // Exhaustive sweep against the shift model.
        for (int i = 0; i < 256; i++) begin
            drive(8'(i), 256'b1 << i);
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        drive(8'h42, 256'h4 << 64);
        @(posedge clk);
        #3;
        in0 = 8'h99;
        #1;
        check("no_comb_path", {out1, out0}, 256'h4 << 64);

        // Async reset between edges after decoding 0xA3 (out1[35]).
        drive(8'hA3, {128'h8_0000_0000, 128'h0});
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {out1, out0}, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        in0 = 8'h10;
        exp_q.push_back(256'h1_0000);

        // Pseudo-random codes.
        for (int i = 0; i < 300; i++) begin
            r = 8'($urandom_range(0, 255));
            drive(r, 256'b1 << r);
        end

        // Bounded drain of the scoreboard.
        repeat (4) @(posedge clk);
        #2;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
